// File: rtl/dma_sched_pkg.sv
// Shared constants, register map and FSM state encoding for the
// multi-channel DMA scheduler.
package dma_sched_pkg;

    localparam logic [1:0] OFF_SRC  = 2'd0;
    localparam logic [1:0] OFF_DST  = 2'd1;
    localparam logic [1:0] OFF_LEN  = 2'd2;
    localparam logic [1:0] OFF_CTRL = 2'd3;

    localparam logic [11:0] ADDR_IRQ_STATUS = 12'h100;
    localparam logic [11:0] ADDR_INFO       = 12'h104;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_DONE   = 2;
    localparam int CTRL_BUSY   = 3;
    localparam int CTRL_PEND   = 4;
    localparam int CTRL_ERR    = 5;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } sched_state_e;

    function automatic logic [31:0] strb_merge(
        input logic [31:0] old_val,
        input logic [31:0] wdata,
        input logic [3:0]  wstrb
    );
        logic [31:0] v;
        v = old_val;
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) v[b*8 +: 8] = wdata[b*8 +: 8];
        end
        return v;
    endfunction

endpackage

// File: rtl/dma_sched_if.sv
// AXI4-Lite control bus and transfer-engine job bus bundles.
interface dma_axil_if;
    logic        s_awvalid;
    logic        s_awready;
    logic [11:0] s_awaddr;
    logic [2:0]  s_awprot;
    logic        s_wvalid;
    logic        s_wready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_bvalid;
    logic        s_bready;
    logic [1:0]  s_bresp;
    logic        s_arvalid;
    logic        s_arready;
    logic [11:0] s_araddr;
    logic [2:0]  s_arprot;
    logic        s_rvalid;
    logic        s_rready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;

    modport slave (
        input  s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb,
        input  s_bready, s_arvalid, s_araddr, s_rready,
        output s_awready, s_wready, s_bvalid, s_bresp,
        output s_arready, s_rvalid, s_rdata, s_rresp
    );

    modport master (
        output s_awvalid, s_awaddr, s_awprot, s_wvalid, s_wdata, s_wstrb,
        output s_bready, s_arvalid, s_araddr, s_arprot, s_rready,
        input  s_awready, s_wready, s_bvalid, s_bresp,
        input  s_arready, s_rvalid, s_rdata, s_rresp
    );
endinterface

interface dma_job_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
);
    logic                  job_valid;
    logic                  job_ready;
    logic [ADDR_WIDTH-1:0] job_src;
    logic [ADDR_WIDTH-1:0] job_dst;
    logic [LEN_WIDTH-1:0]  job_len;
    logic [3:0]            job_channel;
    logic                  job_done;
    logic                  job_error;

    modport master (
        output job_valid, job_src, job_dst, job_len, job_channel,
        input  job_ready, job_done, job_error
    );

    modport slave (
        input  job_valid, job_src, job_dst, job_len, job_channel,
        output job_ready, job_done, job_error
    );
endinterface

// File: rtl/dma_sched_arbiter.sv
// Channel arbiter: round-robin by default, fixed lowest-index priority
// when DMA_SCHED_PRIORITY_EN is defined (no pointer state then).
module dma_sched_arbiter #(
    parameter int NUM_CHANNELS = 4
) (
`ifndef DMA_SCHED_PRIORITY_EN
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_grant_en,
`endif
    input  logic [NUM_CHANNELS-1:0] i_req,
    output logic [NUM_CHANNELS-1:0] o_grant_oh,
    output logic [3:0]              o_grant_idx,
    output logic                    o_grant_any
);

    logic w_found;

    assign o_grant_any = |i_req;

`ifdef DMA_SCHED_PRIORITY_EN
    always_comb begin
        o_grant_oh  = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        for (int n = 0; n < NUM_CHANNELS; n++) begin
            if (!w_found && i_req[n]) begin
                w_found       = 1'b1;
                o_grant_oh[n] = 1'b1;
                o_grant_idx   = 4'(n);
            end
        end
    end
`else
    logic [3:0] r_ptr;
    logic [3:0] w_ptr_nxt;

    // Scan from the pointer upward, wrapping, so the channel after the
    // last grant gets first look.
    always_comb begin
        o_grant_oh  = '0;
        o_grant_idx = '0;
        w_ptr_nxt   = r_ptr;
        w_found     = 1'b0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            for (int n = 0; n < NUM_CHANNELS; n++) begin
                if (!w_found && i_req[n] &&
                    ((int'(r_ptr) + k) % NUM_CHANNELS) == n) begin
                    w_found       = 1'b1;
                    o_grant_oh[n] = 1'b1;
                    o_grant_idx   = 4'(n);
                    w_ptr_nxt     = 4'((n + 1) % NUM_CHANNELS);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_grant_en && o_grant_any) begin
            r_ptr <= w_ptr_nxt;
        end
    end
`endif

endmodule

// File: rtl/dma_channel_scheduler.sv
// N-channel DMA front-end: AXI4-Lite descriptor registers, job scheduler
// FSM and completion/irq tracking. DMA_SCHED_PRIORITY_EN selects fixed priority.
module dma_channel_scheduler
    import dma_sched_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int ADDR_WIDTH   = 32,
    parameter int LEN_WIDTH    = 16
) (
    input  logic       clk,
    input  logic       rst,
    dma_axil_if.slave  s_axil,
    dma_job_if.master  job,
    output logic       o_irq
);

    logic                    r_wr_rdy;
    logic                    r_bvalid;
    logic [1:0]              r_bresp;
    logic                    r_rd_rdy;
    logic                    r_rvalid;
    logic [31:0]             r_rdata;
    logic [1:0]              r_rresp;

    logic [ADDR_WIDTH-1:0]   r_src [NUM_CHANNELS];
    logic [ADDR_WIDTH-1:0]   r_dst [NUM_CHANNELS];
    logic [LEN_WIDTH-1:0]    r_len [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] r_irq_en;
    logic [NUM_CHANNELS-1:0] r_done;
    logic [NUM_CHANNELS-1:0] r_busy;
    logic [NUM_CHANNELS-1:0] r_pend;
    logic [NUM_CHANNELS-1:0] r_err;

    sched_state_e            r_state;
    sched_state_e            w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_job_src;
    logic [ADDR_WIDTH-1:0]   r_job_dst;
    logic [LEN_WIDTH-1:0]    r_job_len;
    logic [3:0]              r_job_ch;
    logic                    r_irq;

    logic                    w_wr_fire;
    logic [3:0]              w_wr_ch;
    logic [1:0]              w_wr_off;
    logic                    w_wr_chan;
    logic                    w_wr_lock;
    logic                    w_wr_ok;
    logic                    w_wr_en;
    logic                    w_rd_fire;
    logic [3:0]              w_rd_ch;
    logic [1:0]              w_rd_off;
    logic                    w_rd_chan;
    logic                    w_rd_ok;
    logic [31:0]             w_rd_data;

    logic [NUM_CHANNELS-1:0] w_grant_oh;
    logic [3:0]              w_grant_idx;
    logic                    w_grant_any;
    logic                    w_grant_fire;
    logic                    w_done_fire;
    logic                    w_job_valid;

    assign s_axil.s_awready = r_wr_rdy;
    assign s_axil.s_wready  = r_wr_rdy;
    assign s_axil.s_bvalid  = r_bvalid;
    assign s_axil.s_bresp   = r_bresp;
    assign s_axil.s_arready = r_rd_rdy;
    assign s_axil.s_rvalid  = r_rvalid;
    assign s_axil.s_rdata   = r_rdata;
    assign s_axil.s_rresp   = r_rresp;

    assign job.job_valid   = w_job_valid;
    assign job.job_src     = r_job_src;
    assign job.job_dst     = r_job_dst;
    assign job.job_len     = r_job_len;
    assign job.job_channel = r_job_ch;
    assign o_irq           = r_irq;

    assign w_wr_fire = r_wr_rdy && s_axil.s_awvalid && s_axil.s_wvalid;
    assign w_rd_fire = r_rd_rdy && s_axil.s_arvalid;

    assign w_wr_ch   = s_axil.s_awaddr[7:4];
    assign w_wr_off  = s_axil.s_awaddr[3:2];
    assign w_wr_chan = (s_axil.s_awaddr[11:8] == 4'd0) &&
                       (s_axil.s_awaddr[1:0] == 2'd0) &&
                       (int'(w_wr_ch) < NUM_CHANNELS);
    assign w_rd_ch   = s_axil.s_araddr[7:4];
    assign w_rd_off  = s_axil.s_araddr[3:2];
    assign w_rd_chan = (s_axil.s_araddr[11:8] == 4'd0) &&
                       (s_axil.s_araddr[1:0] == 2'd0) &&
                       (int'(w_rd_ch) < NUM_CHANNELS);

    // Descriptor fields are frozen while the channel is queued or running.
    always_comb begin
        w_wr_lock = 1'b0;
        for (int n = 0; n < NUM_CHANNELS; n++) begin
            if (w_wr_ch == 4'(n)) w_wr_lock = r_busy[n] | r_pend[n];
        end
    end

    assign w_wr_ok = w_wr_chan && (w_wr_off == OFF_CTRL || !w_wr_lock);
    assign w_wr_en = w_wr_fire && w_wr_ok;

    always_comb begin
        w_rd_data = '0;
        w_rd_ok   = 1'b0;
        if (s_axil.s_araddr == ADDR_IRQ_STATUS) begin
            w_rd_ok   = 1'b1;
            w_rd_data = 32'(r_done & r_irq_en);
        end else if (s_axil.s_araddr == ADDR_INFO) begin
            w_rd_ok   = 1'b1;
            w_rd_data = 32'(NUM_CHANNELS);
        end else if (w_rd_chan) begin
            w_rd_ok = 1'b1;
            for (int n = 0; n < NUM_CHANNELS; n++) begin
                if (w_rd_ch == 4'(n)) begin
                    case (w_rd_off)
                        OFF_SRC: w_rd_data = 32'(r_src[n]);
                        OFF_DST: w_rd_data = 32'(r_dst[n]);
                        OFF_LEN: w_rd_data = 32'(r_len[n]);
                        default: w_rd_data = {26'd0, r_err[n], r_pend[n],
                                              r_busy[n], r_done[n],
                                              r_irq_en[n], 1'b0};
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_rdy <= 1'b0;
            r_bvalid <= 1'b0;
            r_bresp  <= RESP_OKAY;
            r_rd_rdy <= 1'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else begin
            r_wr_rdy <= !r_wr_rdy && s_axil.s_awvalid &&
                        s_axil.s_wvalid && !r_bvalid;
            if (w_wr_fire) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (s_axil.s_bready) begin
                r_bvalid <= 1'b0;
            end
            r_rd_rdy <= !r_rd_rdy && s_axil.s_arvalid && !r_rvalid;
            if (w_rd_fire) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
                r_rresp  <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (s_axil.s_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    // Completion updates come last so they win over a same-cycle W1C.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq_en <= '0;
            r_done   <= '0;
            r_busy   <= '0;
            r_pend   <= '0;
            r_err    <= '0;
            for (int n = 0; n < NUM_CHANNELS; n++) begin
                r_src[n] <= '0;
                r_dst[n] <= '0;
                r_len[n] <= '0;
            end
        end else begin
            for (int n = 0; n < NUM_CHANNELS; n++) begin
                if (w_wr_en && w_wr_ch == 4'(n)) begin
                    case (w_wr_off)
                        OFF_SRC: r_src[n] <= ADDR_WIDTH'(strb_merge(
                            32'(r_src[n]), s_axil.s_wdata, s_axil.s_wstrb));
                        OFF_DST: r_dst[n] <= ADDR_WIDTH'(strb_merge(
                            32'(r_dst[n]), s_axil.s_wdata, s_axil.s_wstrb));
                        OFF_LEN: r_len[n] <= LEN_WIDTH'(strb_merge(
                            32'(r_len[n]), s_axil.s_wdata, s_axil.s_wstrb));
                        default: begin
                            if (s_axil.s_wstrb[0]) begin
                                r_irq_en[n] <= s_axil.s_wdata[CTRL_IRQ_EN];
                                if (s_axil.s_wdata[CTRL_DONE]) begin
                                    r_done[n] <= 1'b0;
                                    r_err[n]  <= 1'b0;
                                end
                                if (s_axil.s_wdata[CTRL_START] &&
                                    !r_pend[n] && !r_busy[n]) begin
                                    if (r_len[n] != '0) r_pend[n] <= 1'b1;
                                    else                r_done[n] <= 1'b1;
                                end
                            end
                        end
                    endcase
                end
                if (w_grant_fire && w_grant_oh[n]) begin
                    r_pend[n] <= 1'b0;
                    r_busy[n] <= 1'b1;
                end
                if (w_done_fire && r_job_ch == 4'(n)) begin
                    r_busy[n] <= 1'b0;
                    r_done[n] <= 1'b1;
                    if (job.job_error) r_err[n] <= 1'b1;
                end
            end
        end
    end

    dma_sched_arbiter #(
        .NUM_CHANNELS (NUM_CHANNELS)
    ) u_arb (
`ifndef DMA_SCHED_PRIORITY_EN
        .clk          (clk),
        .rst          (rst),
        .i_grant_en   (w_grant_fire),
`endif
        .i_req        (r_pend),
        .o_grant_oh   (w_grant_oh),
        .o_grant_idx  (w_grant_idx),
        .o_grant_any  (w_grant_any)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_fire = 1'b0;
        w_job_valid  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_grant_any) begin
                    w_grant_fire = 1'b1;
                    w_state_nxt  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_job_valid = 1'b1;
                if (job.job_ready) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (job.job_done) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_done_fire = (r_state == S_WAIT) && job.job_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_job_src <= '0;
            r_job_dst <= '0;
            r_job_len <= '0;
            r_job_ch  <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_irq   <= |(r_done & r_irq_en);
            if (w_grant_fire) begin
                r_job_ch <= w_grant_idx;
                for (int n = 0; n < NUM_CHANNELS; n++) begin
                    if (w_grant_oh[n]) begin
                        r_job_src <= r_src[n];
                        r_job_dst <= r_dst[n];
                        r_job_len <= r_len[n];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dma_channel_scheduler.sv
// Directed self-checking bench for dma_channel_scheduler (4 channels).
module tb_dma_channel_scheduler;

    logic clk;
    logic rst;
    logic irq;
    logic jv_hs;
    int   n_checks;
    int   n_fail;

    dma_axil_if axil ();
    dma_job_if #(.ADDR_WIDTH(32), .LEN_WIDTH(16)) jb ();

    dma_channel_scheduler #(
        .NUM_CHANNELS (4),
        .ADDR_WIDTH   (32),
        .LEN_WIDTH    (16)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .s_axil (axil.slave),
        .job    (jb.master),
        .o_irq  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d,
                             output logic [1:0] resp);
        int t;
        axil.s_awaddr  = a;
        axil.s_wdata   = d;
        axil.s_wstrb   = 4'hF;
        axil.s_awvalid = 1'b1;
        axil.s_wvalid  = 1'b1;
        t = 0;
        while (!axil.s_awready && t < 20) begin step(); t++; end
        check("aw_handshake", 32'(axil.s_awready), 32'd1);
        step();
        axil.s_awvalid = 1'b0;
        axil.s_wvalid  = 1'b0;
        jv_hs = jb.job_valid;
        t = 0;
        while (!axil.s_bvalid && t < 20) begin step(); t++; end
        check("bvalid", 32'(axil.s_bvalid), 32'd1);
        resp = axil.s_bresp;
        axil.s_bready = 1'b1;
        step();
        axil.s_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [11:0] a, output logic [31:0] d,
                            output logic [1:0] resp);
        int t;
        axil.s_araddr  = a;
        axil.s_arvalid = 1'b1;
        t = 0;
        while (!axil.s_arready && t < 20) begin step(); t++; end
        check("ar_handshake", 32'(axil.s_arready), 32'd1);
        step();
        axil.s_arvalid = 1'b0;
        t = 0;
        while (!axil.s_rvalid && t < 20) begin step(); t++; end
        check("rvalid", 32'(axil.s_rvalid), 32'd1);
        d    = axil.s_rdata;
        resp = axil.s_rresp;
        axil.s_rready = 1'b1;
        step();
        axil.s_rready = 1'b0;
    endtask

    task automatic wr_ok(input logic [11:0] a, input logic [31:0] d);
        logic [1:0] r;
        axi_write(a, d, r);
        check($sformatf("bresp@%h", a), 32'(r), 32'd0);
    endtask

    task automatic rd_chk(input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(a, d, r);
        check($sformatf("rdata@%h", a), d, exp);
        check($sformatf("rresp@%h", a), 32'(r), 32'd0);
    endtask

    task automatic wait_job();
        int t;
        t = 0;
        while (!jb.job_valid && t < 30) begin step(); t++; end
        check("job_valid_wait", 32'(jb.job_valid), 32'd1);
    endtask

    task automatic accept();
        jb.job_ready = 1'b1;
        step();
        jb.job_ready = 1'b0;
    endtask

    task automatic serve(input logic err);
        accept();
        jb.job_done  = 1'b1;
        jb.job_error = err;
        step();
        jb.job_done  = 1'b0;
        jb.job_error = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int          t;
        int          exp_a;
        int          exp_b;
        n_checks = 0;
        n_fail   = 0;
        jv_hs    = 1'b0;
        rst      = 1'b1;
        axil.s_awvalid = 1'b0; axil.s_awaddr = '0; axil.s_awprot = '0;
        axil.s_wvalid  = 1'b0; axil.s_wdata  = '0; axil.s_wstrb  = '0;
        axil.s_bready  = 1'b0; axil.s_arvalid = 1'b0; axil.s_araddr = '0;
        axil.s_arprot  = '0;   axil.s_rready  = 1'b0;
        jb.job_ready = 1'b0; jb.job_done = 1'b0; jb.job_error = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("reset_outs", {25'd0, irq, jb.job_valid, axil.s_awready,
              axil.s_wready, axil.s_bvalid, axil.s_arready,
              axil.s_rvalid}, 32'd0);
        check("reset_job_src", jb.job_src, 32'd0);
        check("reset_rdata", axil.s_rdata, 32'd0);
        rd_chk(12'h104, 32'h4);
        for (int c = 0; c < 4; c++) rd_chk(12'(c * 16 + 12), 32'h0);

        // Single job with interrupt
        wr_ok(12'h000, 32'h1000);
        wr_ok(12'h004, 32'h2000);
        wr_ok(12'h008, 32'd8);
        wr_ok(12'h00C, 32'h3);
        check("jv_at_pend", 32'(jv_hs), 32'd0);
        check("jv_at_+2", 32'(jb.job_valid), 32'd1);
        check("job_src", jb.job_src, 32'h1000);
        check("job_dst", jb.job_dst, 32'h2000);
        check("job_len", 32'(jb.job_len), 32'd8);
        check("job_ch", 32'(jb.job_channel), 32'd0);
        rd_chk(12'h00C, 32'hA);
        check("job_stable", jb.job_src, 32'h1000);
        accept();
        check("jv_after_accept", 32'(jb.job_valid), 32'd0);
        jb.job_done = 1'b1;
        step();
        jb.job_done = 1'b0;
        check("irq_at_+1", 32'(irq), 32'd0);
        step();
        check("irq_at_+2", 32'(irq), 32'd1);
        rd_chk(12'h00C, 32'h6);
        rd_chk(12'h100, 32'h1);
        wr_ok(12'h00C, 32'h4);
        check("irq_cleared", 32'(irq), 32'd0);
        rd_chk(12'h00C, 32'h0);

        // All four channels, two rounds
        for (int c = 1; c < 4; c++) wr_ok(12'(c * 16 + 8), 32'd1);
        for (int rnd = 0; rnd < 2; rnd++) begin
            for (int c = 0; c < 4; c++) wr_ok(12'(c * 16 + 12), 32'h1);
            for (int i = 0; i < 4; i++) begin
                wait_job();
                check($sformatf("order_r%0d_%0d", rnd, i),
                      32'(jb.job_channel), 32'(i));
                serve(1'b0);
            end
        end

        // Pointer sensitivity: ch2 running, then ch1 and ch3 pending
`ifdef DMA_SCHED_PRIORITY_EN
        exp_a = 1; exp_b = 3;
`else
        exp_a = 3; exp_b = 1;
`endif
        wr_ok(12'h02C, 32'h1);
        wr_ok(12'h01C, 32'h1);
        wr_ok(12'h03C, 32'h1);
        wait_job();
        check("arb_first", 32'(jb.job_channel), 32'd2);
        serve(1'b0);
        wait_job();
        check("arb_second", 32'(jb.job_channel), 32'(exp_a));
        serve(1'b0);
        wait_job();
        check("arb_third", 32'(jb.job_channel), 32'(exp_b));
        serve(1'b0);
        for (int c = 0; c < 4; c++) wr_ok(12'(c * 16 + 12), 32'h4);

        // Locked descriptors and unmapped addresses
        wr_ok(12'h01C, 32'h1);
        axi_write(12'h018, 32'h55, r);
        check("len_busy_slverr", 32'(r), 32'd2);
        rd_chk(12'h018, 32'd1);
        rd_chk(12'h01C, 32'h8);
        wr_ok(12'h02C, 32'h1);
        rd_chk(12'h02C, 32'h10);
        axi_write(12'h020, 32'hDEAD, r);
        check("src_pend_slverr", 32'(r), 32'd2);
        rd_chk(12'h020, 32'h0);
        wr_ok(12'h01C, 32'h1);
        rd_chk(12'h01C, 32'h8);
        axi_read(12'h0F0, d, r);
        check("unmapped_rdata", d, 32'h0);
        check("unmapped_rresp", 32'(r), 32'd2);
        axi_write(12'h0F0, 32'h1, r);
        check("unmapped_bresp", 32'(r), 32'd2);

        // Error completion
        check("err_job_ch", 32'(jb.job_channel), 32'd1);
        serve(1'b1);
        rd_chk(12'h01C, 32'h24);
        wait_job();
        check("queued_ch2", 32'(jb.job_channel), 32'd2);
        serve(1'b0);
        rd_chk(12'h02C, 32'h4);
        wr_ok(12'h01C, 32'h4);
        rd_chk(12'h01C, 32'h0);

        // Zero-length start completes without a job
        wr_ok(12'h038, 32'h0);
        wr_ok(12'h03C, 32'h1);
        check("len0_jv_hs", 32'(jv_hs), 32'd0);
        check("len0_jv", 32'(jb.job_valid), 32'd0);
        rd_chk(12'h03C, 32'h4);
        check("len0_jv_late", 32'(jb.job_valid), 32'd0);

        // W1C DONE colliding with job_done: set wins
        wr_ok(12'h00C, 32'h1);
        wait_job();
        accept();
        axil.s_awaddr  = 12'h00C;
        axil.s_wdata   = 32'h4;
        axil.s_wstrb   = 4'hF;
        axil.s_awvalid = 1'b1;
        axil.s_wvalid  = 1'b1;
        t = 0;
        while (!axil.s_awready && t < 20) begin step(); t++; end
        check("collide_aw", 32'(axil.s_awready), 32'd1);
        jb.job_done = 1'b1;
        step();
        jb.job_done    = 1'b0;
        axil.s_awvalid = 1'b0;
        axil.s_wvalid  = 1'b0;
        check("collide_bvalid", 32'(axil.s_bvalid), 32'd1);
        check("collide_bresp", 32'(axil.s_bresp), 32'd0);
        axil.s_bready = 1'b1;
        step();
        axil.s_bready = 1'b0;
        rd_chk(12'h00C, 32'h4);

        // Reset in the middle of a job; late job_done is ignored
        wr_ok(12'h00C, 32'h4);
        wr_ok(12'h00C, 32'h3);
        wait_job();
        accept();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_jv", 32'(jb.job_valid), 32'd0);
        jb.job_done = 1'b1;
        step();
        jb.job_done = 1'b0;
        step();
        check("rst_irq", 32'(irq), 32'd0);
        rd_chk(12'h00C, 32'h0);
        rd_chk(12'h008, 32'h0);
        rd_chk(12'h104, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dma_channel_scheduler.md
# dma_channel_scheduler

Parametrised multi-channel front-end for the DMA engine: an AXI4-Lite register file holding NUM_CHANNELS transfer descriptors, an arbiter that serialises started channels into single jobs for one downstream transfer engine, and per-channel completion/interrupt tracking. It sits between the Renode AXI manager (control bus) and the DMA transfer core, and replaces the fixed two-interrupt control path with a generalised N-channel scheme.

## Interface
- NUM_CHANNELS, 4, channel count, 1..16
- ADDR_WIDTH, 32, transfer address width (src/dst)
- LEN_WIDTH, 16, transfer length width in words
- clock  in  1  single clock, all logic rising-edge
- reset  in  1  asynchronous, active-high reset
- s_aw*/s_w*/s_b*/s_ar*/s_r*  AXI4-Lite subordinate, 32-bit data, 12-bit address, awprot/arprot ignored
- job_valid  out  1  job offered to transfer engine
- job_ready  in  1  engine accepts job
- job_src / job_dst  out  ADDR_WIDTH  source / destination address
- job_len  out  LEN_WIDTH  word count
- job_channel  out  4  originating channel
- job_done  in  1  one-cycle pulse, job finished
- job_error  in  1  qualifies job_done
- irq  out  1  level interrupt

## Operation
- Channel n at byte offset n*0x10: +0x0 SRC, +0x4 DST, +0x8 LEN, +0xC CTRL.
- CTRL bits: 0 START (W, reads 0), 1 IRQ_EN (RW), 2 DONE (W1C), 3 BUSY (RO), 4 PENDING (RO), 5 ERR (RO, cleared with DONE).
- Global: 0x100 IRQ_STATUS (RO, bit n = DONE_n & IRQ_EN_n); 0x104 INFO (RO, NUM_CHANNELS in [4:0]).
- Unmapped address or channel index ≥ NUM_CHANNELS: write dropped, read data 0, response SLVERR.
- Write to SRC/DST/LEN while PENDING or BUSY: dropped, SLVERR.
- START=1 while idle with LEN≠0: PENDING set. START with LEN=0: DONE set next cycle, no job issued. START while PENDING/BUSY: ignored, OKAY.
- Scheduler FSM IDLE→ISSUE→WAIT→IDLE. IDLE: if any PENDING, grant one, latch its descriptor onto job_*, clear PENDING, set BUSY, go ISSUE. ISSUE: job_valid=1 until job_ready, then WAIT. WAIT: on job_done set DONE (and ERR if job_error), clear BUSY, go IDLE.
- job_done outside WAIT: ignored.
- Arbitration: round-robin starting at channel after last grant; pointer resets to 0.
- DONE W1C and job_done for same channel in same cycle: set wins.
- irq = OR of IRQ_STATUS, registered.

## Timing
- Reset: all AXI ready/valid 0, bresp/rresp 0, rdata 0, job_valid 0, job_* 0, irq 0, all registers 0, FSM IDLE.
- Write: awready and wready asserted together for one cycle when both valids high and no B outstanding; bvalid the following cycle, held until bready.
- Read: arready when no R outstanding; rvalid with data the following cycle, held until rready.
- START write to job_valid: 2 cycles (PENDING at +1, job_valid at +2) when FSM IDLE.
- job_done to DONE/irq visible: DONE at +1, irq at +2.
- After WAIT→IDLE, next grant earliest one cycle later; back-to-back jobs have one idle cycle.
- job_* stable while job_valid high.
- Reset mid-job: all state discarded; a late job_done after reset is ignored.

## Configuration
- DMA_SCHED_PRIORITY_EN defined: fixed priority, lowest-numbered pending channel wins; round-robin pointer not built.
- Undefined (default): round-robin as above.

## Structure
- dma_sched_pkg: register offsets, CTRL bit indices, FSM state enum, response codes.
- Sub-module dma_sched_arbiter: NUM_CHANNELS request vector in, one-hot grant plus index out, pointer update on grant; the macro selects its mode.

## Test plan
- Reset then read 0x104 with NUM_CHANNELS=4 -> rdata 0x4, OKAY; all CTRL read 0.
- Program ch0 SRC=0x1000, DST=0x2000, LEN=8, CTRL=0x3 -> job_valid 2 cycles later with those values, job_channel 0; job_done -> CTRL reads 0x6, irq high; write CTRL=0x4 -> irq low.
- START ch0..ch3 same time, engine always ready, instant done -> grant order 0,1,2,3; repeat -> 0,1,2,3 again (with macro: always lowest pending first).
- Write LEN of BUSY channel -> SLVERR, value unchanged; read 0x0F0 with 4 channels -> SLVERR, rdata 0.
- job_done with job_error=1 -> CTRL ERR and DONE set; LEN=0 START -> DONE without job_valid.
- W1C DONE in same cycle as job_done for that channel -> DONE remains 1.
